// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory access stage.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [3:0] BYTE_EN_WORD  = 4'hF;
    localparam logic [3:0] BYTE_EN_LANE0 = 4'h1;

    // Counter width able to hold values up to timeout_cycles.
    function automatic int timeout_cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the core's right-justified operands and the 32-bit bus.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic        access_byte_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0] rdata_byte;

    always_comb begin
        case (lane_i)
            2'd0:    rdata_byte = bus_rdata_i[7:0];
            2'd1:    rdata_byte = bus_rdata_i[15:8];
            2'd2:    rdata_byte = bus_rdata_i[23:16];
            default: rdata_byte = bus_rdata_i[31:24];
        endcase
    end

    always_comb begin
        byte_en_o   = BYTE_EN_WORD;
        wdata_o     = store_data_i;
        load_data_o = bus_rdata_i;
        if (access_byte_i) begin
            // Replicating the byte lets the bus ignore the lane when routing write data.
            byte_en_o   = BYTE_EN_LANE0 << lane_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = {24'b0, rdata_byte};
        end
    end

endmodule

// File: rtl/data_memory_access.sv
// Memory stage: issues one load/store at a time on the request/ack data bus and stalls until done.
module data_memory_access
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              access_byte,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       store_data,
    output logic [31:0]       memory_value,
    output logic              mem_stall,
    output logic              mem_error,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_byte_en,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output dmem_state_t       state_dbg
);

    localparam int TIMEOUT_CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t              state_q, state_d;
    logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]        bus_addr_q, bus_addr_d;
    logic [31:0]              bus_wdata_q, bus_wdata_d;
    logic [3:0]               bus_byte_en_q, bus_byte_en_d;
    logic                     bus_read_q, bus_read_d;
    logic                     bus_write_q, bus_write_d;
    logic [31:0]              mem_value_q, mem_value_d;
    logic                     error_q, error_d;
    logic [1:0]               lane_q, lane_d;
    logic                     byte_q, byte_d;

    logic        req;
    logic        req_bad;
    logic [1:0]  align_lane;
    logic        align_byte;
    logic [3:0]  align_byte_en;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    assign req     = mem_read | mem_write;
    assign req_bad = (mem_read & mem_write) | (~access_byte & (address[1:0] != 2'b00));

    // Request fields steer the lanes in IDLE; the captured lane steers read data in WAIT.
    assign align_lane = (state_q == IDLE) ? address[1:0] : lane_q;
    assign align_byte = (state_q == IDLE) ? access_byte  : byte_q;

    dmem_lane_align u_lane_align (
        .lane_i        (align_lane),
        .access_byte_i (align_byte),
        .store_data_i  (store_data),
        .bus_rdata_i   (bus_rdata),
        .byte_en_o     (align_byte_en),
        .wdata_o       (align_wdata),
        .load_data_o   (align_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_byte_en_q <= '0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            mem_value_q   <= '0;
            error_q       <= 1'b0;
            lane_q        <= '0;
            byte_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_byte_en_q <= bus_byte_en_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
            mem_value_q   <= mem_value_d;
            error_q       <= error_d;
            lane_q        <= lane_d;
            byte_q        <= byte_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_byte_en_d = bus_byte_en_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        mem_value_d   = mem_value_q;
        error_d       = 1'b0;
        lane_d        = lane_q;
        byte_d        = byte_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (req_bad) begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d       = WAIT;
                        cnt_d         = '0;
                        bus_addr_d    = {address[ADDR_W-1:2], 2'b00};
                        bus_wdata_d   = align_wdata;
                        bus_byte_en_d = align_byte_en;
                        bus_read_d    = mem_read;
                        bus_write_d   = mem_write;
                        lane_d        = address[1:0];
                        byte_d        = access_byte;
                    end
                end
            end
            WAIT: begin
                // Ack is tested before expiry so a last-cycle ack still completes cleanly.
                if (bus_ack) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    if (bus_read_q) begin
                        mem_value_d = align_load;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    mem_value_d = '0;
                    error_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_stall    = ~rst & (((state_q == IDLE) & req) | (state_q == WAIT));
    assign mem_error    = error_q;
    assign memory_value = mem_value_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_byte_en  = bus_byte_en_q;
    assign bus_read     = bus_read_q;
    assign bus_write    = bus_write_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_data_memory_access.sv
// Randomised and directed checks of data_memory_access against a transaction-level model.
module tb_data_memory_access;
    import dmem_pkg::*;

    localparam int TO     = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read, mem_write, access_byte;
    logic [ADDR_W-1:0] address;
    logic [31:0]       store_data;
    logic [31:0]       memory_value;
    logic              mem_stall, mem_error;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_byte_en;
    logic              bus_read, bus_write;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    dmem_state_t       state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem = '0;

    data_memory_access #(.TIMEOUT_CYCLES(TO), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .access_byte  (access_byte),
        .address      (address),
        .store_data   (store_data),
        .memory_value (memory_value),
        .mem_stall    (mem_stall),
        .mem_error    (mem_error),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_byte_en  (bus_byte_en),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // One complete transaction; ack_at is the WAIT cycle index carrying ack (>= TO means never).
    task automatic do_txn(input string name, input logic rd, input logic wr, input logic bt,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rd_data, input int ack_at);
        logic        exp_err;
        logic        timed_out;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          lane;
        lane      = int'(addr[1:0]);
        exp_err   = (rd && wr) || (!bt && addr[1:0] != 2'b00);
        exp_be    = bt ? 4'(1 << lane) : 4'hF;
        exp_wd    = bt ? {4{sd[7:0]}} : sd;
        timed_out = 1'b0;

        @(negedge clk);
        mem_read = rd; mem_write = wr; access_byte = bt; address = addr; store_data = sd;
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        checks++;
        if (mem_stall !== 1'b1 || bus_read !== 1'b0 || bus_write !== 1'b0 || mem_error !== 1'b0) begin
            errors++;
            $display("FAIL %s req_cycle: stall/rd/wr/err=%b%b%b%b required 1000", name,
                     mem_stall, bus_read, bus_write, mem_error);
        end

        if (!exp_err) begin
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                bus_ack   = (i == ack_at);
                bus_rdata = bus_ack ? rd_data : $urandom;
                #1;
                checks++;
                if (bus_read !== rd || bus_write !== wr || mem_stall !== 1'b1 || mem_error !== 1'b0) begin
                    errors++;
                    $display("FAIL %s wait%0d: stall/rd/wr/err=%b%b%b%b required 1%b%b0", name, i,
                             mem_stall, bus_read, bus_write, mem_error, rd, wr);
                end
                checks++;
                if (bus_addr !== {addr[31:2], 2'b00} || bus_byte_en !== exp_be ||
                    (wr && bus_wdata !== exp_wd)) begin
                    errors++;
                    $display("FAIL %s bus_fields%0d: addr=%h be=%h wd=%h required %h %h %h", name, i,
                             bus_addr, bus_byte_en, bus_wdata, {addr[31:2], 2'b00}, exp_be, exp_wd);
                end
                if (i == ack_at) break;
                if (i == TO - 1) timed_out = 1'b1;
            end
        end

        // DONE: request still presented, must be ignored
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        if (timed_out) model_mem = '0;
        else if (!exp_err && rd) model_mem = bt ? ((rd_data >> (8 * lane)) & 32'hFF) : rd_data;
        checks++;
        if (mem_stall !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0 ||
            mem_error !== (exp_err || timed_out)) begin
            errors++;
            $display("FAIL %s done: stall/rd/wr/err=%b%b%b%b required 000%b", name,
                     mem_stall, bus_read, bus_write, mem_error, exp_err || timed_out);
        end
        checks++;
        if (memory_value !== model_mem) begin
            errors++;
            $display("FAIL %s memory_value: got %h required %h", name, memory_value, model_mem);
        end

        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || mem_error !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0 ||
            memory_value !== model_mem) begin
            errors++;
            $display("FAIL %s idle_after: stall/err/rd/wr=%b%b%b%b mv=%h required 0000 %h", name,
                     mem_stall, mem_error, bus_read, bus_write, memory_value, model_mem);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 0; mem_write = 0; access_byte = 0; address = '0;
        store_data = '0; bus_rdata = '0; bus_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state_dbg !== IDLE || bus_read !== 0 || bus_write !== 0 || bus_addr !== '0 ||
            bus_wdata !== '0 || bus_byte_en !== '0 || memory_value !== '0 ||
            mem_stall !== 0 || mem_error !== 0) begin
            errors++;
            $display("FAIL reset: state=%0d rd=%b wr=%b addr=%h wd=%h be=%h mv=%h stall=%b err=%b required all zero",
                     state_dbg, bus_read, bus_write, bus_addr, bus_wdata, bus_byte_en,
                     memory_value, mem_stall, mem_error);
        end
        @(negedge clk);
        rst = 1'b0;
        model_mem = '0;
    endtask

    task automatic test_load_store();
        do_txn("lw",  1, 0, 0, 32'h0000_1004, 32'h0,          32'hCAFEBABE, 1);
        do_txn("lb",  1, 0, 1, 32'h0000_2003, 32'h0,          32'h11223344, 0);
        do_txn("sb",  0, 1, 1, 32'h0000_3001, 32'h0000_00A5,  32'h0,        0);
        do_txn("sw",  0, 1, 0, 32'h0000_5008, 32'h1234_5678,  32'h0,        2);
    endtask

    task automatic test_errors();
        do_txn("sw_misaligned", 0, 1, 0, 32'h0000_4002, 32'hDEAD_BEEF, 32'h0, 0);
        do_txn("lw_misaligned", 1, 0, 0, 32'h0000_4001, 32'h0,         32'h0, 0);
        do_txn("rd_wr_conflict", 1, 1, 0, 32'h0000_4000, 32'h0,        32'h0, 0);
    endtask

    task automatic test_timeout();
        do_txn("lw_ok_before_to", 1, 0, 0, 32'h0000_6000, 32'h0, 32'h5555_AAAA, 0);
        do_txn("lw_timeout",      1, 0, 0, 32'h0000_6004, 32'h0, 32'h0,         TO);
        do_txn("lw_ack_at_expiry",1, 0, 0, 32'h0000_6008, 32'h0, 32'h0BAD_F00D, TO - 1);
    endtask

    task automatic test_reset_mid();
        do_txn("lw_pre_reset", 1, 0, 0, 32'h0000_7000, 32'h0, 32'h7777_1111, 0);
        @(negedge clk);
        mem_read = 1; mem_write = 0; access_byte = 0; address = 32'h0000_7004; bus_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus_read !== 1'b1 || mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: rd=%b stall=%b required 1 1", bus_read, mem_stall);
        end
        rst = 1'b1; mem_read = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_mem = '0;
        checks++;
        if (bus_read !== 1'b0 || mem_stall !== 1'b0 || state_dbg !== IDLE || memory_value !== '0) begin
            errors++;
            $display("FAIL reset_mid post: rd=%b stall=%b state=%0d mv=%h required 0 0 0 0",
                     bus_read, mem_stall, state_dbg, memory_value);
        end
        do_txn("lw_after_reset", 1, 0, 0, 32'h0000_7008, 32'h0, 32'h8888_9999, 1);
    endtask

    task automatic test_random();
        logic        rd, wr, bt;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       begin rd = 1; wr = 1; end
                1, 2, 3: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 0; end
            endcase
            bt   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if (!bt && $urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
            do_txn("random", rd, wr, bt, addr, $urandom, $urandom, $urandom_range(0, TO));
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/data_memory_access.md
Name: data_memory_access

Overview:
- Memory stage of the rv32 pipeline, directly upstream of writeback.
- Turns load/store requests (address from ALU, store data from register file) into a single-outstanding request/ack transaction on the data bus.
- Stalls the pipeline until the bus responds.
- Delivers the aligned load result as memory_value; writeback selects it and zero-extends byte loads from memory_value[7:0].

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for bus_ack before abort (1..65535)
ADDR_W, 32, address width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
mem_read  input  1  load request from decode/execute
mem_write  input  1  store request
access_byte  input  1  1 = byte access (LB/SB), 0 = word
address  input  ADDR_W  effective address (ALU result)
store_data  input  32  store operand
memory_value  output  32  load result to writeback, byte loads right-justified in [7:0]
mem_stall  output  1  freeze upstream stages
mem_error  output  1  one-cycle pulse: misaligned, read+write conflict, or timeout
bus_addr  output  ADDR_W  word-aligned bus address (address[1:0] forced 0)
bus_wdata  output  32  store data, byte replicated on all lanes for SB
bus_byte_en  output  4  lane enables
bus_read  output  1  read strobe, held until ack
bus_write  output  1  write strobe, held until ack
bus_rdata  input  32  read data, valid with bus_ack
bus_ack  input  1  transaction complete

Behaviour:
- Reset values (sync): state IDLE, all bus_* = 0, memory_value = 0, mem_stall = 0, mem_error = 0, timeout counter = 0.
- Reset mid-transaction: strobes drop at the reset edge. No data is captured.
- States: IDLE, WAIT, DONE.
- IDLE, when req = mem_read|mem_write:
  - mem_stall = 1 combinationally in the same cycle.
  - Request is checked first. Error if both mem_read and mem_write are high, or if a word access has address[1:0] != 0.
  - Error case: next state DONE with mem_error=1. No bus strobe. memory_value unchanged.
  - Otherwise: register bus_addr/bus_wdata/bus_byte_en and the strobe, then go to WAIT.
- WAIT:
  - mem_stall=1; strobe and bus fields held stable.
  - Counter increments each cycle.
  - bus_ack=1: drop strobe next edge. On loads, capture the aligned read data into memory_value. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: drop strobe, memory_value=0, mem_error=1 in DONE.
  - Ack arriving on the same cycle as expiry wins (no error).
- DONE:
  - mem_stall=0 for exactly one cycle; pipeline advances on this edge.
  - New requests are ignored in DONE. Next state is IDLE unconditionally.
- Minimum load latency: request cycle + 1 WAIT cycle with ack + DONE = 3 cycles.
- Byte lanes, lane = address[1:0]:
  - Stores: SB sets bus_byte_en = 1<<lane and bus_wdata = {4{store_data[7:0]}}. SW sets bus_byte_en = 4'hF and bus_wdata = store_data.
  - Loads: LB gives memory_value = {24'b0, bus_rdata[8*lane+:8]}. LW gives memory_value = bus_rdata.
  - Loads drive bus_byte_en as for stores of the same size.
- memory_value holds its last load result across stores, errors (except timeout) and idle cycles.
- mem_error is high only in DONE.

Decomposition:
- Shared package dmem_pkg:
  - enum dmem_state_t {IDLE, WAIT, DONE}.
  - localparams BYTE_EN_WORD=4'hF, TIMEOUT_CNT_W=$clog2(TIMEOUT_CYCLES+1).
- One sub-module dmem_lane_align, purely combinational: lane, access_byte, store_data, bus_rdata -> byte_en, wdata, aligned load data. Reused by any future halfword support.
- FSM, counter and registers stay in data_memory_access.

Test Plan:
- LW 0x0000_1004, ack after 2 WAIT cycles, rdata 0xCAFEBABE -> bus_read high 2 cycles, bus_addr 0x1004, byte_en F; memory_value=0xCAFEBABE in DONE; mem_stall high 3 cycles then low 1.
- LB 0x0000_2003, rdata 0x11223344 -> byte_en 4'b1000, memory_value=0x00000011.
- SB 0x0000_3001, store_data 0x000000A5, immediate ack -> bus_write 1 cycle, byte_en 4'b0010, wdata 0xA5A5A5A5; memory_value unchanged.
- SW 0x0000_4002 -> no bus strobe, mem_error pulse 1 cycle, stall 1 cycle. mem_read=mem_write=1 -> same response.
- LW with no ack, TIMEOUT_CYCLES=4 -> strobe high 4 cycles then dropped, mem_error=1, memory_value=0. Repeat with ack on 4th cycle -> data captured, no error.
- Assert rst during WAIT -> bus_read=0, mem_stall=0 after that edge, state IDLE; a subsequent LW completes normally.
